// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
package alu_arb_pkg;
   localparam int N_REQ = 2;
   localparam int CNT_W = 8;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_NOT = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_OR  = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_GT  = 3'd6;
   localparam logic [2:0] OP_EQ  = 3'd7;

   localparam int Y_ZERO  = 6;
   localparam int Y_OVF   = 5;
   localparam int Y_CARRY = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the arbiter.
interface alu_arbiter_if;
   import alu_arb_pkg::*;

   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_ready;
   logic [2:0]       req_op0;
   logic [2:0]       req_op1;
   logic [3:0]       req_a0;
   logic [3:0]       req_a1;
   logic [3:0]       req_b0;
   logic [3:0]       req_b1;
   logic [N_REQ-1:0] rsp_valid;
   logic [N_REQ-1:0] rsp_ready;
   logic [6:0]       rsp_data;
   logic [CNT_W-1:0] done_cnt0;
   logic [CNT_W-1:0] done_cnt1;
   logic             busy;

   modport master (
      output req_valid, req_op0, req_op1,
      output req_a0, req_a1, req_b0, req_b1,
      output rsp_ready,
      input  req_ready, rsp_valid, rsp_data,
      input  done_cnt0, done_cnt1, busy
   );

   modport slave (
      input  req_valid, req_op0, req_op1,
      input  req_a0, req_a1, req_b0, req_b1,
      input  rsp_ready,
      output req_ready, rsp_valid, rsp_data,
      output done_cnt0, done_cnt1, busy
   );
endinterface

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU producing {zero, overflow, carry, result}.
module alu4_core
   import alu_arb_pkg::*;
(
   input  logic [2:0] op,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [6:0] y
);
   logic       is_sub;
   logic [3:0] bx;
   logic [4:0] sum;

   // sub reuses the adder as a + ~b + 1
   assign is_sub = (op == OP_SUB);
   assign bx     = is_sub ? ~b : b;
   assign sum    = {1'b0, a} + {1'b0, bx} + {4'b0, is_sub};

   always_comb begin
      y = '0;
      case (op)
         OP_ADD, OP_SUB: begin
            y[3:0]    = sum[3:0];
            y[Y_CARRY] = sum[4];
            y[Y_OVF]   = (a[3] == bx[3]) && (sum[3] != a[3]);
            y[Y_ZERO]  = (sum[3:0] == 4'd0);
         end
         OP_NOT: y[3:0] = ~a;
         OP_AND: y[3:0] = a & b;
         OP_OR:  y[3:0] = a | b;
         OP_XOR: y[3:0] = a ^ b;
         OP_GT:  y[0]   = $signed(a) > $signed(b);
         OP_EQ:  y[0]   = (a == b);
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU between two requesters.
module alu_arbiter
   import alu_arb_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);
   state_t           state;
   state_t           state_nx;
   logic             prio;
   logic             owner;
   logic [2:0]       op_q;
   logic [3:0]       a_q;
   logic [3:0]       b_q;
   logic [6:0]       y;
   logic [6:0]       data_q;
   logic [1:0]       grant;
   logic [1:0]       ready;
   logic [1:0]       rvalid;
   logic             accept;
   logic             rsp_hs;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   alu4_core u_alu (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .y  (y)
   );

   always_comb begin
      grant = '0;
      unique case (1'b1)
         (bus.req_valid == 2'b01): grant = 2'b01;
         (bus.req_valid == 2'b10): grant = 2'b10;
         (bus.req_valid == 2'b11): grant = prio ? 2'b10 : 2'b01;
         default:                  grant = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ready    = '0;
      rvalid   = '0;
      accept   = 1'b0;
      rsp_hs   = 1'b0;
      unique case (state)
         S_IDLE: begin
            ready  = grant;
            accept = |grant;
            if (accept) state_nx = S_EXEC;
         end
         S_EXEC: state_nx = S_RESP;
         S_RESP: begin
            rvalid = owner ? 2'b10 : 2'b01;
            rsp_hs = bus.rsp_ready[owner];
            if (rsp_hs) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio   <= 1'b0;
         owner  <= 1'b0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         data_q <= '0;
         cnt0   <= '0;
         cnt1   <= '0;
      end else begin
         if (accept) begin
            owner <= grant[1];
            op_q  <= grant[1] ? bus.req_op1 : bus.req_op0;
            a_q   <= grant[1] ? bus.req_a1 : bus.req_a0;
            b_q   <= grant[1] ? bus.req_b1 : bus.req_b0;
         end
         if (state == S_EXEC) data_q <= y;
         if (rsp_hs) begin
            prio <= ~owner;
            if (owner) cnt1 <= cnt1 + 1'b1;
            else       cnt0 <= cnt0 + 1'b1;
         end
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rvalid;
   assign bus.rsp_data  = data_q;
   assign bus.done_cnt0 = cnt0;
   assign bus.done_cnt1 = cnt1;
   assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised bench for alu_arbiter against a behavioural ALU/arbiter model.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if bus();

   alu_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int exp_cnt[2];
   int mprio;
   logic [2:0] t_op[2];
   logic [3:0] t_a[2];
   logic [3:0] t_b[2];

   function automatic logic [6:0] model(
      input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int ua, ub, sa, sb, r, res;
      logic z, v, c;
      ua = int'(a); ub = int'(b);
      sa = a[3] ? ua - 16 : ua;
      sb = b[3] ? ub - 16 : ub;
      z = 0; v = 0; c = 0; res = 0;
      case (op)
         3'd0: begin
            r = ua + ub; res = r % 16; c = (r > 15);
            v = (sa + sb > 7) || (sa + sb < -8);
            z = (res == 0);
         end
         3'd1: begin
            res = (ua - ub + 16) % 16; c = (ua >= ub);
            v = (sa - sb > 7) || (sa - sb < -8);
            z = (res == 0);
         end
         3'd2: res = 15 - ua;
         3'd3: res = int'(a & b);
         3'd4: res = int'(a | b);
         3'd5: res = int'(a ^ b);
         3'd6: res = (sa > sb) ? 1 : 0;
         default: res = (ua == ub) ? 1 : 0;
      endcase
      return {z, v, c, 4'(res)};
   endfunction

   task automatic set_req(input int w, input logic [2:0] op,
                          input logic [3:0] a, input logic [3:0] b);
      t_op[w] = op; t_a[w] = a; t_b[w] = b;
      if (w == 0) begin
         bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
      end else begin
         bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
      end
   endtask

   task automatic set_rand(input int w);
      set_req(w, 3'($urandom), 4'($urandom), 4'($urandom));
   endtask

   // Expects requester w to be the one granted; runs its transaction.
   task automatic serve(input int w, input int stall);
      logic [1:0] oh;
      logic [6:0] exp;
      int n;
      oh  = (w == 0) ? 2'b01 : 2'b10;
      exp = model(t_op[w], t_a[w], t_b[w]);
      n = 0;
      #1;
      while (bus.req_ready !== oh && n < 8) begin
         @(negedge clk); #1; n++;
      end
      n_chk++;
      if (bus.req_ready !== oh) begin
         n_fail++;
         $display("FAIL grant%0d: req_ready=%b want %b",
                  w, bus.req_ready, oh);
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid[w] = 1'b0;
      set_rand(w);
      #1;
      n_chk++;
      if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL exec%0d: rsp_valid=%b busy=%b want 00/1",
                  w, bus.rsp_valid, bus.busy);
      end
      @(negedge clk); #1;
      n_chk++;
      if (bus.rsp_valid !== oh || bus.rsp_data !== exp) begin
         n_fail++;
         $display("FAIL resp%0d: valid=%b data=%h want %b/%h",
                  w, bus.rsp_valid, bus.rsp_data, oh, exp);
      end
      for (int s = 0; s < stall; s++) begin
         bus.rsp_ready = ~oh;
         @(negedge clk); #1;
         n_chk++;
         if (bus.rsp_valid !== oh || bus.rsp_data !== exp ||
             bus.req_ready !== 2'b00 ||
             bus.done_cnt0 !== 8'(exp_cnt[0]) ||
             bus.done_cnt1 !== 8'(exp_cnt[1])) begin
            n_fail++;
            $display("FAIL stall%0d: v=%b d=%h rr=%b c=%0d/%0d want %b/%h/00/%0d/%0d",
                     w, bus.rsp_valid, bus.rsp_data, bus.req_ready,
                     bus.done_cnt0, bus.done_cnt1, oh, exp,
                     exp_cnt[0] % 256, exp_cnt[1] % 256);
         end
      end
      bus.rsp_ready = oh;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 2'b00;
      exp_cnt[w] = (exp_cnt[w] + 1) % 256;
      mprio = 1 - w;
      #1;
      n_chk++;
      if (bus.done_cnt0 !== 8'(exp_cnt[0]) ||
          bus.done_cnt1 !== 8'(exp_cnt[1]) ||
          bus.rsp_valid !== 2'b00) begin
         n_fail++;
         $display("FAIL done%0d: cnt=%0d/%0d v=%b want %0d/%0d/00",
                  w, bus.done_cnt0, bus.done_cnt1, bus.rsp_valid,
                  exp_cnt[0], exp_cnt[1]);
      end
   endtask

   task automatic test_reset();
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      set_req(0, 3'd0, 4'd0, 4'd0);
      set_req(1, 3'd0, 4'd0, 4'd0);
      exp_cnt[0] = 0; exp_cnt[1] = 0; mprio = 0;
      repeat (2) @(negedge clk);
      #1;
      n_chk++;
      if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 ||
          bus.rsp_data !== 7'h00 || bus.busy !== 1'b0 ||
          bus.done_cnt0 !== 8'd0 || bus.done_cnt1 !== 8'd0) begin
         n_fail++;
         $display("FAIL reset: rr=%b v=%b d=%h busy=%b c=%0d/%0d",
                  bus.req_ready, bus.rsp_valid, bus.rsp_data,
                  bus.busy, bus.done_cnt0, bus.done_cnt1);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add_ovf();
      set_req(0, OP_ADD, 4'd7, 4'd1);
      bus.req_valid = 2'b01;
      serve(0, 0);
   endtask

   task automatic test_sub_zero();
      set_req(1, OP_SUB, 4'd3, 4'd3);
      bus.req_valid = 2'b10;
      serve(1, 1);
   endtask

   task automatic test_contention();
      set_req(0, OP_EQ, 4'd5, 4'd5);
      set_req(1, OP_GT, 4'd2, 4'hE);
      bus.req_valid = 2'b11;
      serve(0, 0);
      set_rand(0);
      bus.req_valid[0] = 1'b1;
      serve(1, 0);
      serve(0, 0);
   endtask

   task automatic test_backpressure();
      set_rand(1);
      bus.req_valid = 2'b10;
      serve(1, 5);
   endtask

   task automatic test_random();
      int mask, w;
      for (int k = 0; k < 40; k++) begin
         mask = int'($urandom_range(1, 3));
         if (mask[0]) set_rand(0);
         if (mask[1]) set_rand(1);
         bus.req_valid = 2'(mask);
         while (mask != 0) begin
            if (mask == 3) w = mprio;
            else           w = (mask == 1) ? 0 : 1;
            serve(w, int'($urandom_range(0, 2)));
            mask = mask & ~(1 << w);
         end
      end
   endtask

   task automatic test_reset_mid_exec();
      int n;
      set_rand(1);
      bus.req_valid = 2'b10;
      n = 0;
      #1;
      while (bus.req_ready !== 2'b10 && n < 8) begin
         @(negedge clk); #1; n++;
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 2'b00;
      #1;
      n_chk++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_busy: busy=%b want 1", bus.busy);
      end
      #2 rst_n = 1'b0;
      #1;
      exp_cnt[0] = 0; exp_cnt[1] = 0; mprio = 0;
      n_chk++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 ||
          bus.rsp_data !== 7'h00 || bus.req_ready !== 2'b00 ||
          bus.done_cnt0 !== 8'd0 || bus.done_cnt1 !== 8'd0) begin
         n_fail++;
         $display("FAIL async_rst: busy=%b v=%b d=%h rr=%b c=%0d/%0d",
                  bus.busy, bus.rsp_valid, bus.rsp_data,
                  bus.req_ready, bus.done_cnt0, bus.done_cnt1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         n_chk++;
         if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst%0d: v=%b busy=%b want 00/0",
                     i, bus.rsp_valid, bus.busy);
         end
      end
   endtask

   task automatic test_counter_wrap();
      set_rand(1);
      bus.req_valid = 2'b10;
      serve(1, 0);
      for (int i = 0; i < 256; i++) begin
         set_rand(0);
         bus.req_valid = 2'b01;
         serve(0, 0);
      end
      n_chk++;
      if (bus.done_cnt0 !== 8'd0 || bus.done_cnt1 !== 8'd1) begin
         n_fail++;
         $display("FAIL wrap: cnt0=%0d cnt1=%0d want 0/1",
                  bus.done_cnt0, bus.done_cnt1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: sim time %0t exceeded", $time);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_add_ovf();
      test_sub_zero();
      test_contention();
      test_backpressure();
      test_random();
      test_reset_mid_exec();
      test_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Sequences the team's shared 4-bit ALU and shares it between two requesters.
- Arbitration is round-robin.
- Each request (opcode, A, B) is accepted over a valid/ready handshake and its operands are latched.
- The ALU evaluates the latched operands, and the 7-bit result {zero, overflow, carry, result[3:0]} is returned to the owning requester under a response valid/ready handshake.

## Interface
- `N_REQ`, 2: number of requesters; fixed at 2, not scalable in this revision.
- `CNT_W`, 8: width of the per-requester completion counters.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  2  bit i: requester i presents an operation.
- `req_ready`  out  2  bit i: arbiter accepts requester i this cycle.
- `req_op0`, `req_op1`  in  3 each  opcode: 0 add, 1 sub, 2 not A, 3 and, 4 or, 5 xor, 6 signed A>B, 7 A==B.
- `req_a0`, `req_a1`, `req_b0`, `req_b1`  in  4 each  operands.
- `rsp_valid`  out  2  bit i: result available for requester i.
- `rsp_ready`  in  2  bit i: requester i consumes the result.
- `rsp_data`  out  7  ALU result: [6] zero, [5] overflow, [4] carry, [3:0] result.
- `done_cnt0`, `done_cnt1`  out  `CNT_W` each  completed-transaction counters, wrap 255→0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE: on an accept, latch op/A/B/owner and go to EXEC.
  - EXEC: register the ALU output into `rsp_data` and go to RESP.
  - RESP: hold `rsp_valid[owner]` high. When `rsp_ready[owner]` is seen, increment `done_cnt[owner]`, set `prio` to the other requester, and go to IDLE.
- Grant, evaluated in IDLE only:
  - If exactly one `req_valid` bit is set, that requester is granted.
  - If both are set, requester `prio` is granted.
  - `prio` resets to 0.
- `req_ready` is one-hot or zero, is combinational from the FSM state, `req_valid` and `prio`, and is never high outside IDLE.
- Accept happens when `req_valid[i]` and `req_ready[i]` are both high.
- The ALU sees only latched operands; requester inputs may change freely after accept.
- `rsp_data` and `rsp_valid` are stable while `rsp_valid` is high and `rsp_ready` is low.
- `rsp_valid` is never high for the non-owner.
- `rsp_ready` asserted on the non-owner bit, or outside RESP, is ignored.
- ALU arithmetic rules:
  - add: A+B, 5-bit with carry.
  - sub: A+~B+1, with carry.
  - Overflow: operands share a sign bit and the result sign differs. For sub, the second operand is ~B.
  - Zero: result[3:0]==0.
  - Opcodes 2–5: [6:4]=0.
  - Opcodes 6 and 7: only bit 0 is meaningful; [6:1]=0.
- Counters wrap; no saturation.

## Timing
- Reset values: state IDLE, `prio` 0, `rsp_data` 0, `rsp_valid` 0, `req_ready` 0, `busy` 0, both counters 0.
- Latency:
  - Accept at cycle N.
  - `rsp_valid` high from cycle N+2.
  - Minimum 3 cycles per transaction (accept, EXEC, RESP with `rsp_ready` already high).
  - Next accept no earlier than N+3.
- Simultaneous requests at N: requester `prio` is served. The loser keeps `req_valid` high and is served next; no starvation.
- Reset is asynchronous mid-transaction: the in-flight operation is discarded, with no response and no counter increment.

## Structure
- Package `alu_arb_pkg`:
  - opcode localparams: `OP_ADD` … `OP_EQ`.
  - FSM state enum: `S_IDLE`, `S_EXEC`, `S_RESP`.
  - result bit-index constants: `Y_ZERO`=6, `Y_OVF`=5, `Y_CARRY`=4.
- One sub-module, `alu4_core`: the purely combinational 4-bit ALU (op[2:0], A, B → Y[6:0]), instantiated once.
- Arbiter, FSM, operand latches and counters live in `alu_arbiter`.

## Test plan
- Add with overflow: req0 op0, A=7, B=1 → `rsp_valid`=2'b01 at N+2, `rsp_data`=7'h28; `done_cnt0`=1 after `rsp_ready`.
- Subtract to zero: req1 op1, A=3, B=3 → `rsp_data`=7'h50 (zero=1, carry=1); `rsp_valid`=2'b10.
- Simultaneous requests after reset: both valid, op7 A=5 B=5 / op6 A=2 B=4'hE. Req0 is served first (7'h01), then req1 (7'h01). A third contention grants req0 again only after req1 completes.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_data` stable, `req_ready`=0 throughout, counter unchanged until the handshake.
- Reset mid-EXEC: drop `rst_n` asynchronously → all outputs return to reset values immediately, with no response after release.
- Counter wrap: 256 completions on req0 → `done_cnt0` returns to 0, `done_cnt1` unaffected.
